branch_resolve_unit: RTL and testbench

Resolution end of the branch prediction path. Fetch pushes each fetched instruction's PC, taken prediction and predicted target into an in-order tracking FIFO. When the instruction leaves EX, the block pops the matching entry and compares the prediction with the actual outcome. It then drives the BHT update port, the fetch redirect/flush, and branch/mispredict performance counters.

---
 rtl/branch_resolve_unit.sv | 136 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolution: tracks fetched predictions in an in-order FIFO, checks them
// against EX outcomes, and drives BHT training, fetch redirect and perf counters.
module branch_resolve_unit #(
    parameter int DEPTH   = 4,
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_fetch_valid,
    input  logic [31:0]        i_fetch_pc,
    input  logic               i_fetch_pred_taken,
    input  logic [31:0]        i_fetch_pred_target,
    output logic               o_fetch_ready,
    input  logic               i_ex_valid,
    input  logic [31:0]        i_ex_pc,
    input  logic               i_ex_is_branch,
    input  logic               i_ex_taken,
    input  logic [31:0]        i_ex_target,
    output logic               o_upd_valid,
    output logic [31:0]        o_upd_pc,
    output logic               o_upd_taken,
    output logic               o_redirect,
    output logic [31:0]        o_redirect_pc,
    output logic [COUNT_W-1:0] o_branch_count,
    output logic [COUNT_W-1:0] o_mispredict_count,
    output logic               o_sync_error
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      pc_mem_r     [DEPTH];
    logic             taken_mem_r  [DEPTH];
    logic [31:0]      target_mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic        full_s;
    logic        empty_s;
    logic        push_s;
    logic        pop_s;
    logic        head_taken_s;
    logic [31:0] head_target_s;
    logic [31:0] head_pc_s;
    logic        mispredict_s;
    logic        sync_err_s;
    logic [31:0] corr_pc_s;

    assign full_s        = (count_r == CNT_W'(DEPTH));
    assign empty_s       = (count_r == {CNT_W{1'b0}});
    assign o_fetch_ready = !full_s && !o_redirect;
    assign push_s        = i_fetch_valid && o_fetch_ready;
    // EX traffic seen while a redirect is on the bus belongs to the wrong path.
    assign pop_s         = i_ex_valid && !empty_s && !o_redirect;

    assign head_pc_s     = pc_mem_r[rd_ptr_r];
    assign head_taken_s  = taken_mem_r[rd_ptr_r];
    assign head_target_s = target_mem_r[rd_ptr_r];
    assign corr_pc_s     = (i_ex_is_branch && i_ex_taken) ? i_ex_target : (i_ex_pc + 32'd4);

    // Prediction check against the head entry and tracking-consistency check.
    always_comb begin
        mispredict_s = 1'b0;
        sync_err_s   = 1'b0;
        if (pop_s) begin
            if (i_ex_is_branch) begin
                mispredict_s = (i_ex_taken != head_taken_s) ||
                               (i_ex_taken && (i_ex_target != head_target_s));
            end else begin
                mispredict_s = head_taken_s;
            end
            sync_err_s = (head_pc_s != i_ex_pc);
        end else begin
            sync_err_s = i_ex_valid && !o_redirect && empty_s;
        end
    end

    // Tracking storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]     <= i_fetch_pc;
            taken_mem_r[wr_ptr_r]  <= i_fetch_pred_taken;
            target_mem_r[wr_ptr_r] <= i_fetch_pred_target;
        end
    end

    // Pointer/occupancy update; a mispredict flushes everything including this cycle's push.
    always_ff @(posedge clk) begin
        if (rst || mispredict_s) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Registered resolution outputs; data fields hold while their strobe is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_upd_valid        <= 1'b0;
            o_upd_pc           <= 32'd0;
            o_upd_taken        <= 1'b0;
            o_redirect         <= 1'b0;
            o_redirect_pc      <= 32'd0;
            o_branch_count     <= {COUNT_W{1'b0}};
            o_mispredict_count <= {COUNT_W{1'b0}};
            o_sync_error       <= 1'b0;
        end else begin
            o_upd_valid <= pop_s && i_ex_is_branch;
            o_redirect  <= mispredict_s;
            if (pop_s && i_ex_is_branch) begin
                o_upd_pc    <= i_ex_pc;
                o_upd_taken <= i_ex_taken;
                if (o_branch_count != {COUNT_W{1'b1}}) begin
                    o_branch_count <= o_branch_count + COUNT_W'(1);
                end
            end
            if (mispredict_s) begin
                o_redirect_pc <= corr_pc_s;
                if (o_mispredict_count != {COUNT_W{1'b1}}) begin
                    o_mispredict_count <= o_mispredict_count + COUNT_W'(1);
                end
            end
            if (sync_err_s) begin
                o_sync_error <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a queue-based reference model checked
// every cycle, plus literal pins; a 2-bit-counter instance exercises saturation.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fv, fpt, ev, ebr, etk;
    logic [31:0] fpc, ftgt, epc, etgt;

    logic        ready, upd_valid, upd_taken, redir, serr;
    logic [31:0] upd_pc, redir_pc, bcnt, mcnt;
    logic        s_ready, s_upd_valid, s_upd_taken, s_redir, s_serr;
    logic [31:0] s_upd_pc, s_redir_pc;
    logic [1:0]  s_bcnt, s_mcnt;

    always #5 clk = ~clk;

    branch_resolve_unit #(.DEPTH(DEPTH), .COUNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_fetch_valid(fv), .i_fetch_pc(fpc), .i_fetch_pred_taken(fpt),
        .i_fetch_pred_target(ftgt), .o_fetch_ready(ready),
        .i_ex_valid(ev), .i_ex_pc(epc), .i_ex_is_branch(ebr), .i_ex_taken(etk),
        .i_ex_target(etgt),
        .o_upd_valid(upd_valid), .o_upd_pc(upd_pc), .o_upd_taken(upd_taken),
        .o_redirect(redir), .o_redirect_pc(redir_pc),
        .o_branch_count(bcnt), .o_mispredict_count(mcnt), .o_sync_error(serr)
    );

    branch_resolve_unit #(.DEPTH(DEPTH), .COUNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .i_fetch_valid(fv), .i_fetch_pc(fpc), .i_fetch_pred_taken(fpt),
        .i_fetch_pred_target(ftgt), .o_fetch_ready(s_ready),
        .i_ex_valid(ev), .i_ex_pc(epc), .i_ex_is_branch(ebr), .i_ex_taken(etk),
        .i_ex_target(etgt),
        .o_upd_valid(s_upd_valid), .o_upd_pc(s_upd_pc), .o_upd_taken(s_upd_taken),
        .o_redirect(s_redir), .o_redirect_pc(s_redir_pc),
        .o_branch_count(s_bcnt), .o_mispredict_count(s_mcnt), .o_sync_error(s_serr)
    );

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
    } ent_t;

    ent_t        q[$];
    logic        x_uv, x_ut, x_rd, x_err;
    logic [31:0] x_upc, x_rpc, x_bc, x_mc;
    logic [1:0]  x_bc2, x_mc2;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour for one clock edge, evaluated from the current inputs.
    task automatic model_step();
        logic full, pop, push, mis, br_pop;
        ent_t h;
        if (rst) begin
            q.delete();
            x_uv = 0; x_ut = 0; x_rd = 0; x_err = 0;
            x_upc = 0; x_rpc = 0; x_bc = 0; x_mc = 0; x_bc2 = 0; x_mc2 = 0;
            return;
        end
        full   = (q.size() == DEPTH);
        push   = fv && !full && !x_rd;
        pop    = ev && (q.size() != 0) && !x_rd;
        mis    = 1'b0;
        br_pop = pop && ebr;
        if (ev && !x_rd && q.size() == 0) x_err = 1'b1;
        if (pop) begin
            h = q[0];
            if (h.pc != epc) x_err = 1'b1;
            mis = ebr ? ((etk != h.pt) || (etk && etgt != h.tgt)) : h.pt;
        end
        x_uv = br_pop;
        if (br_pop) begin
            x_upc = epc;
            x_ut  = etk;
            if (x_bc != 32'hFFFF_FFFF) x_bc++;
            if (x_bc2 != 2'b11) x_bc2++;
        end
        x_rd = mis;
        if (mis) begin
            x_rpc = (ebr && etk) ? etgt : epc + 32'd4;
            if (x_mc != 32'hFFFF_FFFF) x_mc++;
            if (x_mc2 != 2'b11) x_mc2++;
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{pc: fpc, pt: fpt, tgt: ftgt});
        end
    endtask

    task automatic check_all();
        chk("upd_valid", {31'd0, upd_valid}, {31'd0, x_uv});
        chk("upd_pc", upd_pc, x_upc);
        chk("upd_taken", {31'd0, upd_taken}, {31'd0, x_ut});
        chk("redirect", {31'd0, redir}, {31'd0, x_rd});
        chk("redirect_pc", redir_pc, x_rpc);
        chk("branch_count", bcnt, x_bc);
        chk("mispredict_count", mcnt, x_mc);
        chk("sync_error", {31'd0, serr}, {31'd0, x_err});
        chk("sat_branch_count", {30'd0, s_bcnt}, {30'd0, x_bc2});
        chk("sat_mispredict_count", {30'd0, s_mcnt}, {30'd0, x_mc2});
    endtask

    // One clock: drive at negedge, check combinational ready, model, check outputs after edge.
    task automatic cyc(input logic f_v, input logic [31:0] f_pc, input logic f_pt,
                       input logic [31:0] f_tgt, input logic e_v, input logic [31:0] e_pc,
                       input logic e_br, input logic e_tk, input logic [31:0] e_tgt);
        fv = f_v; fpc = f_pc; fpt = f_pt; ftgt = f_tgt;
        ev = e_v; epc = e_pc; ebr = e_br; etk = e_tk; etgt = e_tgt;
        #1;
        if (!rst) chk("fetch_ready", {31'd0, ready}, {31'd0, (q.size() != DEPTH) && !x_rd});
        model_step();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        cyc(1'b1, pc, pt, tgt, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic pop(input logic [31:0] pc, input logic br, input logic tk, input logic [31:0] tgt);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, pc, br, tk, tgt);
    endtask

    task automatic idle();
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        fv = 0; fpc = 0; fpt = 0; ftgt = 0; ev = 0; epc = 0; ebr = 0; etk = 0; etgt = 0;
        @(negedge clk);
        do_reset();
        chk("pin_reset_bcnt", bcnt, 32'd0);
        chk("pin_reset_ready", {31'd0, ready}, 32'd1);

        // correctly predicted not-taken branch
        push(32'h100, 1'b0, 32'h0);
        pop(32'h100, 1'b1, 1'b0, 32'h0);
        chk("pin_upd_valid", {31'd0, x_uv}, 32'd1);
        chk("pin_upd_pc", x_upc, 32'h100);
        chk("pin_bcnt1", x_bc, 32'd1);
        chk("pin_no_redirect", {31'd0, x_rd}, 32'd0);

        // NT predicted, taken: pushes in pop cycle and redirect cycle are lost
        push(32'h200, 1'b0, 32'h0);
        cyc(1'b1, 32'h204, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 1'b1, 32'h340);
        chk("pin_redir_pc_340", x_rpc, 32'h340);
        chk("pin_mcnt1", x_mc, 32'd1);
        push(32'h208, 1'b0, 32'h0);
        chk("pin_flushed_empty", q.size(), 32'd0);
        idle();

        // taken with wrong target, then taken predicted but not taken
        push(32'h300, 1'b1, 32'h400);
        pop(32'h300, 1'b1, 1'b1, 32'h480);
        chk("pin_redir_pc_480", x_rpc, 32'h480);
        idle();
        push(32'h300, 1'b1, 32'h400);
        pop(32'h300, 1'b1, 1'b0, 32'h0);
        chk("pin_redir_pc_304", x_rpc, 32'h304);
        idle();

        // non-branch predicted taken, including PC wrap
        push(32'h500, 1'b1, 32'h800);
        pop(32'h500, 1'b0, 1'b0, 32'h0);
        chk("pin_redir_pc_504", x_rpc, 32'h504);
        chk("pin_nb_upd_valid", {31'd0, x_uv}, 32'd0);
        idle();
        push(32'hFFFF_FFFC, 1'b1, 32'h10);
        pop(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        chk("pin_redir_pc_wrap", x_rpc, 32'h0);
        idle();

        // fill, reject when full (also with simultaneous pop), drain in order
        for (int i = 0; i < 5; i++) push(32'h600 + 32'(4 * i), 1'b0, 32'h0);
        chk("pin_full", q.size(), 32'd4);
        cyc(1'b1, 32'h614, 1'b0, 32'h0, 1'b1, 32'h600, 1'b1, 1'b0, 32'h0);
        for (int i = 1; i < 4; i++) pop(32'h600 + 32'(4 * i), 1'b1, 1'b0, 32'h0);
        chk("pin_drained", q.size(), 32'd0);
        push(32'h700, 1'b0, 32'h0);
        cyc(1'b1, 32'h704, 1'b0, 32'h0, 1'b1, 32'h700, 1'b1, 1'b0, 32'h0);
        pop(32'h704, 1'b1, 1'b0, 32'h0);
        chk("pin_no_sync_err", {31'd0, x_err}, 32'd0);

        // EX on empty FIFO makes sync error sticky
        pop(32'h900, 1'b1, 1'b0, 32'h0);
        chk("pin_sync_err_empty", {31'd0, x_err}, 32'd1);
        idle();
        idle();

        // mismatched PC on pop, after a reset
        do_reset();
        push(32'h800, 1'b0, 32'h0);
        pop(32'h804, 1'b1, 1'b0, 32'h0);
        chk("pin_sync_err_pc", {31'd0, x_err}, 32'd1);
        chk("pin_upd_pc_ex", x_upc, 32'h804);

        // repeated mispredicts drive the 2-bit counters into saturation
        for (int i = 0; i < 4; i++) begin
            push(32'hA00 + 32'(16 * i), 1'b0, 32'h0);
            pop(32'hA00 + 32'(16 * i), 1'b1, 1'b1, 32'hB00);
            idle();
        end
        chk("pin_sat_bcnt", {30'd0, x_bc2}, 32'd3);
        chk("pin_sat_mcnt", {30'd0, x_mc2}, 32'd3);
        chk("pin_bcnt5", x_bc, 32'd5);

        // mid-operation reset discards pending entries
        push(32'hC00, 1'b1, 32'h0);
        do_reset();
        idle();
        chk("pin_reset_empty", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
